// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the
// prefetching fetch stage and its queues.
package fetch_pkg;

  localparam int PC_STEP   = 4;
  localparam int TAG_WIDTH = 4;

  typedef struct packed {
    logic [31:0]          instr;
    logic [31:0]          pc;
    logic [TAG_WIDTH-1:0] tag;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_MRET,
    RD_TRAP,
    RD_JUMP
  } redirect_e;

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: req/gnt/rvalid instruction
// memory port; master = fetch, slave = memory.
interface fetch_prefetch_if;

  logic        i_req;
  logic [31:0] i_address;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  modport master (
    output i_req,
    output i_address,
    input  i_gnt,
    input  i_rvalid,
    input  i_rdata
  );

  modport slave (
    input  i_req,
    input  i_address,
    output i_gnt,
    output i_rvalid,
    output i_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-deep synchronous FIFO with flush,
// head word visible combinationally on dout.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && !flush && (cnt_q != '0);
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push)
                    - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= din;
  end

  assign dout  = mem[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: pipelined fetch with tagged response FIFO.
// Define FETCH_PERF_EN for flush/starve perf counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDRESS = 32'h0,
  parameter int          DEPTH         = 4,
  parameter int          TAG_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              hazard,
  input  logic              jump,
  input  logic [31:0]       result,
  input  logic [31:0]       mtvec,
  input  logic [31:0]       mepc,
  input  logic              exception_raised,
  input  logic              interrupt_ack,
  input  logic              machine_return,
  fetch_prefetch_if.master  imem,
  output logic [31:0]       instruction,
  output logic [31:0]       NPC,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_starve_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = 32 + TAG_W;
  localparam int EW = 64 + TAG_W;

  redirect_e      rd_kind;
  logic           redirect;
  logic [31:0]    target;
  logic [31:0]    pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]  disc_q, disc_d;
  logic [CW-1:0]  fifo_cnt, infl_cnt;
  logic [PW-1:0]  infl_head;
  logic [EW-1:0]  head;
  logic           granted, push, pop;

  always_comb begin
    rd_kind = RD_NONE;
    unique case (1'b1)
      machine_return:
        rd_kind = RD_MRET;
      !machine_return &&
      (exception_raised || interrupt_ack):
        rd_kind = RD_TRAP;
      !machine_return && !exception_raised &&
      !interrupt_ack && jump:
        rd_kind = RD_JUMP;
      default:
        rd_kind = RD_NONE;
    endcase
  end

  always_comb begin
    unique case (rd_kind)
      RD_MRET: target = mepc;
      RD_TRAP: target = mtvec;
      default: target = result;
    endcase
  end

  assign redirect = (rd_kind != RD_NONE);

  assign imem.i_req = !reset && !redirect &&
    (({1'b0, fifo_cnt} + {1'b0, infl_cnt})
      < (CW+1)'(DEPTH));
  assign imem.i_address = pc_q;

  assign granted   = imem.i_req && imem.i_gnt;
  assign valid_out = (fifo_cnt != '0);
  assign push = imem.i_rvalid && (disc_q == '0)
                && !redirect;
  assign pop  = valid_out && !stall && !hazard
                && !redirect;

  always_comb begin
    pc_d   = pc_q;
    tag_d  = tag_q;
    disc_d = disc_q;
    if (redirect) begin
      pc_d  = target;
      tag_d = tag_q + 1'b1;
      // every request still in flight is stale now
      disc_d = infl_cnt - CW'(imem.i_rvalid);
    end else begin
      if (granted) pc_d = pc_q + 32'(PC_STEP);
      if (imem.i_rvalid && disc_q != '0)
        disc_d = disc_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= START_ADDRESS;
      tag_q  <= '0;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      tag_q  <= tag_d;
      disc_q <= disc_d;
    end
  end

  fetch_fifo #(.W(PW), .DEPTH(DEPTH)) u_infl (
    .clk   (clk),
    .rst   (reset),
    .flush (1'b0),
    .push  (granted),
    .din   ({pc_q, tag_q}),
    .pop   (imem.i_rvalid),
    .dout  (infl_head),
    .count (infl_cnt)
  );

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_resp (
    .clk   (clk),
    .rst   (reset),
    .flush (redirect),
    .push  (push),
    .din   ({imem.i_rdata, infl_head}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt)
  );

  always_comb begin
    {instruction, NPC, tag_out} = '0;
    if (valid_out)
      {instruction, NPC, tag_out} = head;
  end

  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (reset)
    imem.i_rvalid |-> infl_cnt != '0);

`ifdef FETCH_PERF_EN
  logic [31:0] flush_q, flush_d;
  logic [31:0] starve_q, starve_d;

  always_comb begin
    flush_d  = flush_q + 32'(redirect);
    starve_d = starve_q +
      32'(!valid_out && !stall && !hazard);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q  <= '0;
      starve_q <= '0;
    end else begin
      flush_q  <= flush_d;
      starve_q <= starve_d;
    end
  end

  assign perf_flush_cnt  = flush_q;
  assign perf_starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed vectors and redirect
// sequences against a 1-cycle-latency memory model.
module tb_fetch_prefetch;

  logic        clk;
  logic        reset;
  logic        stall, hazard, jump;
  logic [31:0] result, mtvec, mepc;
  logic        exc, intack, mret;
  logic [31:0] instruction, npc;
  logic [3:0]  tag_out;
  logic        valid_out;
  logic        gnt_en, hold;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_flush, pf_starve;
`endif

  fetch_prefetch_if mbus ();

  fetch_prefetch #(
    .START_ADDRESS (32'h0),
    .DEPTH         (4),
    .TAG_W         (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .hazard           (hazard),
    .jump             (jump),
    .result           (result),
    .mtvec            (mtvec),
    .mepc             (mepc),
    .exception_raised (exc),
    .interrupt_ack    (intack),
    .machine_return   (mret),
    .imem             (mbus.master),
    .instruction      (instruction),
    .NPC              (npc),
    .tag_out          (tag_out),
    .valid_out        (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_flush_cnt   (pf_flush),
    .perf_starve_cnt  (pf_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: grants when gnt_en, answers in order,
  // rdata = ~address, one cycle after the grant
  logic [31:0] pend [$];
  assign mbus.i_gnt = gnt_en;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      mbus.i_rvalid <= 1'b0;
      mbus.i_rdata  <= 32'h0;
    end else begin
      if (mbus.i_req && mbus.i_gnt)
        pend.push_back(mbus.i_address);
      if (!hold && pend.size() > 0) begin
        mbus.i_rvalid <= 1'b1;
        mbus.i_rdata  <= ~pend.pop_front();
      end else begin
        mbus.i_rvalid <= 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // sample current cycle first; return on the
  // negedge after the observed pop commits
  task automatic next_pop(output logic [31:0] n,
                          output logic [31:0] ins,
                          output logic [3:0]  tg);
    logic got;
    got = 1'b0;
    n   = 32'hDEAD_BEEF;
    ins = 32'hDEAD_BEEF;
    tg  = 4'hF;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (valid_out && !stall && !hazard &&
          !(jump || exc || intack || mret)) begin
        n   = npc;
        ins = instruction;
        tg  = tag_out;
        got = 1'b1;
      end
      @(negedge clk);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL pop_timeout: got none want pop");
    end
  endtask

  task automatic next_req(output logic [31:0] a);
    logic got;
    got = 1'b0;
    a   = 32'hDEAD_BEEF;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (mbus.i_req) begin
        a   = mbus.i_address;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL req_timeout: got none want req");
    end
  endtask

  task automatic pulse(input logic j, input logic e,
                       input logic m,
                       input logic [31:0] r,
                       input logic [31:0] tv,
                       input logic [31:0] ep);
    jump = j; exc = e; mret = m;
    result = r; mtvec = tv; mepc = ep;
    @(negedge clk);
    jump = 1'b0; exc = 1'b0; mret = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0; hazard = 1'b0;
    jump = 1'b0; exc = 1'b0;
    intack = 1'b0; mret = 1'b0;
    gnt_en = 1'b1; hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        hazard;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] npc;
  } vec_t;

  vec_t        tv [8];
  logic [31:0] n, ins, a;
  logic [3:0]  tg;
  int          grants;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 0, 1, 32'h00, 0, 32'h00};
    tv[1] = '{0, 0, 1, 32'h04, 0, 32'h00};
    tv[2] = '{0, 0, 1, 32'h08, 1, 32'h00};
    tv[3] = '{0, 0, 1, 32'h0C, 1, 32'h04};
    tv[4] = '{0, 1, 1, 32'h10, 1, 32'h08};
    tv[5] = '{0, 0, 1, 32'h14, 1, 32'h08};
    tv[6] = '{0, 0, 1, 32'h18, 1, 32'h0C};
    tv[7] = '{0, 0, 1, 32'h1C, 1, 32'h10};

    result = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    reset = 1'b1;
    stall = 1'b0; hazard = 1'b0;
    jump = 1'b0; exc = 1'b0;
    intack = 1'b0; mret = 1'b0;
    gnt_en = 1'b1; hold = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mbus.i_req), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_addr", mbus.i_address, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_npc", npc, 32'h0);
    chk("rst_tag", 32'(tag_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // streaming, one hazard bubble
    for (int i = 0; i < 8; i++) begin
      stall  = tv[i].stall;
      hazard = tv[i].hazard;
      #1;
      chk($sformatf("v%0d_req", i),
          32'(mbus.i_req), 32'(tv[i].req));
      chk($sformatf("v%0d_addr", i),
          mbus.i_address, tv[i].addr);
      chk($sformatf("v%0d_valid", i),
          32'(valid_out), 32'(tv[i].valid));
      if (tv[i].valid) begin
        chk($sformatf("v%0d_npc", i),
            npc, tv[i].npc);
        chk($sformatf("v%0d_instr", i),
            instruction, ~tv[i].npc);
        chk($sformatf("v%0d_tag", i),
            32'(tag_out), 32'h0);
      end else begin
        chk($sformatf("v%0d_instr0", i),
            instruction, 32'h0);
      end
      @(negedge clk);
    end

    // stall held: four grants, then fill
    do_reset();
    stall  = 1'b1;
    grants = 0;
    repeat (10) begin
      #1;
      if (mbus.i_req && gnt_en) grants++;
      @(negedge clk);
    end
    #1;
    chk("stall_grants", 32'(grants), 32'd4);
    chk("stall_req", 32'(mbus.i_req), 32'h0);
    chk("stall_valid", 32'(valid_out), 32'h1);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_pop(n, ins, tg);
      chk($sformatf("stall_pop%0d_npc", k),
          n, 32'(k * 4));
      chk($sformatf("stall_pop%0d_instr", k),
          ins, ~32'(k * 4));
      chk($sformatf("stall_pop%0d_tag", k),
          32'(tg), 32'h0);
    end

    // jump with three requests outstanding
    do_reset();
    hold = 1'b1;
    repeat (3) @(negedge clk);
    gnt_en = 1'b0;
    #1;
    chk("out3_req", 32'(mbus.i_req), 32'h1);
    chk("out3_addr", mbus.i_address, 32'hC);
    chk("out3_valid", 32'(valid_out), 32'h0);
    pulse(1, 0, 0, 32'h100, 32'h0, 32'h0);
    gnt_en = 1'b1;
    hold   = 1'b0;
    next_req(a);
    chk("jmp_req", a, 32'h100);
    next_pop(n, ins, tg);
    chk("jmp_npc", n, 32'h100);
    chk("jmp_instr", ins, ~32'h100);
    chk("jmp_tag", 32'(tg), 32'h1);
    next_pop(n, ins, tg);
    chk("jmp_npc2", n, 32'h104);

    // trap beats jump, then mret
    do_reset();
    repeat (3) @(negedge clk);
    pulse(1, 1, 0, 32'h200, 32'h80, 32'h44);
    next_req(a);
    chk("trap_req", a, 32'h80);
    next_pop(n, ins, tg);
    chk("trap_npc", n, 32'h80);
    chk("trap_tag", 32'(tg), 32'h1);
    pulse(0, 0, 1, 32'h200, 32'h80, 32'h44);
    next_req(a);
    chk("mret_req", a, 32'h44);
    next_pop(n, ins, tg);
    chk("mret_npc", n, 32'h44);
    chk("mret_instr", ins, ~32'h44);
    chk("mret_tag", 32'(tg), 32'h2);

    // 16 back-to-back jumps: tag wraps to 0
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      jump   = 1'b1;
      result = 32'h1000 + 32'(i * 'h40);
      @(negedge clk);
    end
    jump = 1'b0;
    next_pop(n, ins, tg);
    chk("b2b_npc", n, 32'h13C0);
    chk("b2b_instr", ins, ~32'h13C0);
    chk("b2b_tag", 32'(tg), 32'h0);
    next_pop(n, ins, tg);
    chk("b2b_npc2", n, 32'h13C4);

    for (int i = 0; i < 15; i++) begin
      jump   = 1'b1;
      result = 32'h2000 + 32'(i * 'h40);
      @(negedge clk);
    end
    jump = 1'b0;
    next_pop(n, ins, tg);
    chk("t15_npc", n, 32'h2380);
    chk("t15_tag", 32'(tg), 32'hF);
    pulse(1, 0, 0, 32'h3000, 32'h0, 32'h0);
    next_pop(n, ins, tg);
    chk("wrap_npc", n, 32'h3000);
    chk("wrap_tag", 32'(tg), 32'h0);

    // asynchronous reset mid-burst
    do_reset();
    pulse(1, 0, 0, 32'h500, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("pre_valid", 32'(valid_out), 32'h1);
    chk("pre_tag", 32'(tag_out), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req", 32'(mbus.i_req), 32'h0);
    chk("ar_valid", 32'(valid_out), 32'h0);
    chk("ar_addr", mbus.i_address, 32'h0);
    chk("ar_instr", instruction, 32'h0);
    chk("ar_npc", npc, 32'h0);
    chk("ar_tag", 32'(tag_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    next_req(a);
    chk("ar_req_addr", a, 32'h0);
    next_pop(n, ins, tg);
    chk("ar_pop_npc", n, 32'h0);
    chk("ar_pop_instr", ins, ~32'h0);
    chk("ar_pop_tag", 32'(tg), 32'h0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
